lock_controller: RTL and testbench
==================================

# lock_controller

Attempt sequencer for the combination-lock detector. Converts debounced button levels into single-cycle `zero`/`one` symbol pulses and counts symbols per attempt. Judges each attempt from the detector's `unlock` flag, then clears the detector between attempts. Enforces a lockout after repeated failures and an entry timeout, and relocks on request (optionally on a timer). Sits between the keypad front-end and the detector; the detector's `reset` input is driven only by this block.

## Interface
- `DIGITS`, 6: symbols per attempt (detector code length).
- `MAX_FAILS`, 3: consecutive failed attempts that trigger lockout; 1..15.
- `LOCKOUT_CYCLES`, 1000: lockout duration in clocks.
- `ENTRY_TIMEOUT`, 500: maximum idle clocks between symbols inside an attempt.
- `OPEN_CYCLES`, 2000: auto-relock delay (used only with the macro).
- `CW`, 16: width of the shared timer; all cycle parameters must be < 2^CW.
- `clk`  in  1  single clock; everything is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_zero`  in  1  debounced, synchronous level of the "0" key.
- `btn_one`  in  1  debounced, synchronous level of the "1" key.
- `lock_req`  in  1  level; relock request while open.
- `det_unlock`  in  1  detector `unlock` output.
- `det_zero`  out  1  one-cycle symbol pulse to the detector `zero` input.
- `det_one`  out  1  one-cycle symbol pulse to the detector `one` input.
- `det_reset`  out  1  detector reset, active-high.
- `unlocked`  out  1  high while the lock is open.
- `locked_out`  out  1  high during lockout.
- `attempt_active`  out  1  high while in ENTRY or CHECK.
- `fail_count`  out  4  consecutive failures.

## Operation
- All outputs are registered. Reset values: `det_reset`=1; all other outputs 0; state IDLE; `btn_*` history registers 0.
- Symbol detection: a rise is `btn & ~btn_prev`.
  - A symbol is issued only when exactly one key rises in a cycle. A simultaneous rise of both keys is discarded.
  - Symbols are accepted only in IDLE and ENTRY. Rises in any other state are discarded, and history is still updated.
- States:
  - IDLE: on a symbol, pulse the matching `det_*`, set digit count to 1, clear the timer, go to ENTRY.
  - ENTRY: on each symbol, pulse, increment the count and clear the timer. When the issued symbol makes count == DIGITS, go to CHECK. If the timer reaches ENTRY_TIMEOUT with no symbol, go to CLEAR; `fail_count` is unchanged.
  - CHECK: one cycle; sample `det_unlock`. If 1, go to OPEN and set `fail_count`←0. If 0, go to FAIL.
  - FAIL: one cycle; `fail_count`←`fail_count`+1. If the new value == MAX_FAILS, go to LOCKOUT and clear the timer; otherwise go to CLEAR.
  - LOCKOUT: `locked_out`=1. When the timer reaches LOCKOUT_CYCLES-1, set `fail_count`←0 and go to CLEAR.
  - OPEN: `unlocked`=1. On `lock_req`=1, go to CLEAR.
  - CLEAR: one cycle; `det_reset`=1, digit count←0, go to IDLE.
- `det_reset` is 1 only in reset and CLEAR; `det_zero` and `det_one` are never high together.

## Timing
- Rise sampled at edge n → `det_*` high for the single cycle n+1 → detector updates at edge n+2.
- Last symbol pulse in cycle k → CHECK occupies cycle k+1, with `det_unlock` valid then → `unlocked` rises in cycle k+2.
- Wrong attempt: CHECK, FAIL, CLEAR, IDLE in consecutive cycles. `fail_count` updates in the cycle after FAIL.
- Lockout lasts exactly LOCKOUT_CYCLES cycles with `locked_out`=1, then CLEAR.
- `lock_req` sampled high in OPEN → `unlocked` falls the next cycle, in which `det_reset` is 1.
- Asynchronous reset mid-attempt, mid-lockout or while open forces the reset values immediately. The partial attempt is lost and `fail_count` is 0.

## Configuration
- `LOCK_CTRL_AUTO_RELOCK_EN` defined:
  - OPEN clears the timer on entry.
  - OPEN goes to CLEAR when `lock_req`=1 or the timer reaches OPEN_CYCLES-1, whichever comes first.
  - `unlocked` is high for at most OPEN_CYCLES cycles.
- Not defined: OPEN is left only via `lock_req`; OPEN_CYCLES is unused.

## Test plan
- Symbols 0,1,1,0,0,1 spaced 3 cycles → six single-cycle pulses, CHECK, then `unlocked`=1 two cycles after the last pulse; `fail_count`=0.
- Three attempts of 1,1,1,1,1,1 → `fail_count` 1,2,3; `locked_out`=1 for exactly 1000 cycles. Presses during lockout produce no pulses. Afterwards `fail_count`=0 and `det_reset` pulses once.
- Both keys rising in the same cycle, and a held key → no pulse, and the digit count is unchanged.
- Two symbols, then 500 idle cycles → CLEAR with a `det_reset` pulse and IDLE; `fail_count` unchanged.
- `reset_n` low mid-entry (after 3 symbols) → immediate `det_reset`=1 and all other outputs 0. A full correct code after release unlocks.
- Open lock: `lock_req`=1 → relock next cycle. With the macro and no request → relock after 2000 cycles; without the macro → stays open.

Source files
------------

// File: rtl/lock_controller_if.sv
// Signal bundle between lock_controller, the keypad front-end and the detector.
// master is the controller side; slave is the keypad/detector environment.
interface lock_controller_if;
   logic       btn_zero;
   logic       btn_one;
   logic       lock_req;
   logic       det_unlock;
   logic       det_zero;
   logic       det_one;
   logic       det_reset;
   logic       unlocked;
   logic       locked_out;
   logic       attempt_active;
   logic [3:0] fail_count;

   modport master (
      input  btn_zero, btn_one, lock_req, det_unlock,
      output det_zero, det_one, det_reset, unlocked, locked_out, attempt_active, fail_count
   );

   modport slave (
      output btn_zero, btn_one, lock_req, det_unlock,
      input  det_zero, det_one, det_reset, unlocked, locked_out, attempt_active, fail_count
   );
endinterface

// File: rtl/lock_controller.sv
// Attempt sequencer for the combination-lock detector: symbol pulses, judging, lockout, relock.
// Define LOCK_CTRL_AUTO_RELOCK_EN to relock automatically after OPEN_CYCLES open cycles.
module lock_controller #(
   parameter int unsigned DIGITS         = 6,
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 1000,
   parameter int unsigned ENTRY_TIMEOUT  = 500,
   parameter int unsigned OPEN_CYCLES    = 2000,
   parameter int unsigned CW             = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   lock_controller_if.master bus
);
   localparam int unsigned NW = $clog2(DIGITS + 1);

   if ((ENTRY_TIMEOUT >> CW) != 0 || (LOCKOUT_CYCLES >> CW) != 0 || (OPEN_CYCLES >> CW) != 0 ||
       MAX_FAILS == 0 || MAX_FAILS > 15) begin : g_bad_params
      $error("lock_controller: parameter out of range");
   end

   typedef enum logic [2:0] {
      StIdle, StEntry, StCheck, StFail, StLockout, StOpen, StClear
   } state_e;

   state_e          state_q, state_d;
   logic [NW-1:0]   digits_q, digits_d;
   logic [CW-1:0]   timer_q, timer_d;
   logic [3:0]      fails_q, fails_d;
   logic            prev_zero_q, prev_one_q;
   logic            det_zero_q, det_zero_d;
   logic            det_one_q, det_one_d;
   logic            det_reset_q, unlocked_q, locked_out_q, active_q;
   logic            rise_zero, rise_one, symbol;

   assign rise_zero = bus.btn_zero & ~prev_zero_q;
   assign rise_one  = bus.btn_one & ~prev_one_q;
   assign symbol    = rise_zero ^ rise_one;

   always_comb begin
      state_d    = state_q;
      digits_d   = digits_q;
      timer_d    = timer_q + CW'(1);
      fails_d    = fails_q;
      det_zero_d = 1'b0;
      det_one_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (symbol) begin
               det_zero_d = rise_zero;
               det_one_d  = rise_one;
               digits_d   = NW'(1);
               timer_d    = '0;
               state_d    = StEntry;
            end
         end
         StEntry: begin
            // Hold one cycle after the last pulse so the detector has absorbed it before CHECK.
            if (digits_q == NW'(DIGITS)) begin
               state_d = StCheck;
            end else if (symbol) begin
               det_zero_d = rise_zero;
               det_one_d  = rise_one;
               digits_d   = digits_q + NW'(1);
               timer_d    = '0;
            end else if (timer_q == CW'(ENTRY_TIMEOUT)) begin
               state_d = StClear;
            end
         end
         StCheck: begin
            if (bus.det_unlock) begin
               fails_d = '0;
               timer_d = '0;
               state_d = StOpen;
            end else begin
               state_d = StFail;
            end
         end
         StFail: begin
            fails_d = fails_q + 4'd1;
            if (fails_d == 4'(MAX_FAILS)) begin
               timer_d = '0;
               state_d = StLockout;
            end else begin
               state_d = StClear;
            end
         end
         StLockout: begin
            if (timer_q == CW'(LOCKOUT_CYCLES - 1)) begin
               fails_d = '0;
               state_d = StClear;
            end
         end
         StOpen: begin
`ifdef LOCK_CTRL_AUTO_RELOCK_EN
            if (bus.lock_req || timer_q == CW'(OPEN_CYCLES - 1)) state_d = StClear;
`else
            if (bus.lock_req) state_d = StClear;
`endif
         end
         StClear: begin
            digits_d = '0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         digits_q     <= '0;
         timer_q      <= '0;
         fails_q      <= '0;
         prev_zero_q  <= 1'b0;
         prev_one_q   <= 1'b0;
         det_zero_q   <= 1'b0;
         det_one_q    <= 1'b0;
         det_reset_q  <= 1'b1;
         unlocked_q   <= 1'b0;
         locked_out_q <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         digits_q     <= digits_d;
         timer_q      <= timer_d;
         fails_q      <= fails_d;
         prev_zero_q  <= bus.btn_zero;
         prev_one_q   <= bus.btn_one;
         det_zero_q   <= det_zero_d;
         det_one_q    <= det_one_d;
         det_reset_q  <= (state_d == StClear);
         unlocked_q   <= (state_d == StOpen);
         locked_out_q <= (state_d == StLockout);
         active_q     <= (state_d == StEntry) || (state_d == StCheck);
      end
   end

   assign bus.det_zero       = det_zero_q;
   assign bus.det_one        = det_one_q;
   assign bus.det_reset      = det_reset_q;
   assign bus.unlocked       = unlocked_q;
   assign bus.locked_out     = locked_out_q;
   assign bus.attempt_active = active_q;
   assign bus.fail_count     = fails_q;
endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios plus random keypad traffic against a
// phase-level reference model; a small detector stub recognises the code 0,1,1,0,0,1.
module tb_lock_controller;
   localparam int unsigned DIGITS         = 6;
   localparam int unsigned MAX_FAILS      = 3;
   localparam int unsigned LOCKOUT_CYCLES = 1000;
   localparam int unsigned ENTRY_TIMEOUT  = 500;
   localparam int unsigned OPEN_CYCLES    = 2000;
`ifdef LOCK_CTRL_AUTO_RELOCK_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   lock_controller_if bus ();

   lock_controller #(
      .DIGITS(DIGITS), .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
      .ENTRY_TIMEOUT(ENTRY_TIMEOUT), .OPEN_CYCLES(OPEN_CYCLES), .CW(16)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Detector stub: remembers symbols since its last reset.
   logic [5:0] det_hist = '0;
   int         det_n = 0;
   always @(posedge clk) begin
      if (bus.det_reset) begin
         det_hist <= '0;
         det_n    <= 0;
      end else if (bus.det_zero || bus.det_one) begin
         det_hist <= {det_hist[4:0], bus.det_one};
         det_n    <= det_n + 1;
      end
   end
   assign bus.det_unlock = (det_n >= 6) && (det_hist == 6'b011001);

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase name plus plain counters, advanced once per clock.
   string ph = "RESET";
   int    digits, idle, left, fails;
   bit    p0, p1, r0, r1, e_zero, e_one;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ph = "RESET"; digits = 0; idle = 0; left = 0; fails = 0;
         p0 = 0; p1 = 0; e_zero = 0; e_one = 0;
      end else begin
         r0 = bus.btn_zero && !p0;
         r1 = bus.btn_one && !p1;
         p0 = bus.btn_zero;
         p1 = bus.btn_one;
         e_zero = 0;
         e_one  = 0;
         if ((ph == "IDLE" || ph == "RESET" || (ph == "ENTRY" && digits < DIGITS)) && r0 != r1)
         begin
            e_zero = r0; e_one = r1; digits++; idle = 0; ph = "ENTRY";
         end else if (ph == "ENTRY") begin
            if (digits == DIGITS) ph = "CHECK";
            else if (idle == ENTRY_TIMEOUT) ph = "CLEAR";
            else idle++;
         end else if (ph == "CHECK") begin
            if (bus.det_unlock) begin fails = 0; left = OPEN_CYCLES; ph = "OPEN"; end
            else ph = "FAIL";
         end else if (ph == "FAIL") begin
            fails++;
            if (fails == MAX_FAILS) begin left = LOCKOUT_CYCLES; ph = "LOCKOUT"; end
            else ph = "CLEAR";
         end else if (ph == "LOCKOUT") begin
            left--;
            if (left == 0) begin fails = 0; ph = "CLEAR"; end
         end else if (ph == "OPEN") begin
            left--;
            if (bus.lock_req || (AUTO && left == 0)) ph = "CLEAR";
         end else if (ph == "CLEAR") begin
            digits = 0; ph = "IDLE";
         end else begin
            ph = "IDLE";
         end
      end
   end

   always @(negedge clk) begin
      check("det_zero", bus.det_zero, e_zero);
      check("det_one", bus.det_one, e_one);
      check("det_reset", bus.det_reset, (ph == "CLEAR" || ph == "RESET") ? 1 : 0);
      check("unlocked", bus.unlocked, (ph == "OPEN") ? 1 : 0);
      check("locked_out", bus.locked_out, (ph == "LOCKOUT") ? 1 : 0);
      check("attempt_active", bus.attempt_active, (ph == "ENTRY" || ph == "CHECK") ? 1 : 0);
      check("fail_count", bus.fail_count, fails);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Key high for hold cycles, then low for two.
   task automatic press(input bit key, input int hold);
      if (key) bus.btn_one = 1'b1;
      else bus.btn_zero = 1'b1;
      tick(hold);
      bus.btn_zero = 1'b0;
      bus.btn_one  = 1'b0;
      tick(2);
   endtask

   task automatic enter(input logic [5:0] code);
      for (int i = 5; i >= 0; i--) press(code[i], 1);
   endtask

   logic [5:0] code_ok = 6'b011001;
   logic [5:0] code_bad = 6'b111111;
   int         n;

   initial begin
      bus.btn_zero = 1'b0;
      bus.btn_one  = 1'b0;
      bus.lock_req = 1'b0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      check("rst_det_reset", bus.det_reset, 1);
      check("rst_unlocked", bus.unlocked, 0);
      check("rst_fail_count", bus.fail_count, 0);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      // Correct code with hand-timed last symbol.
      for (int i = 5; i >= 1; i--) press(code_ok[i], 1);
      bus.btn_one = 1'b1;
      tick(1);
      bus.btn_one = 1'b0;
      check("last_pulse_one", bus.det_one, 1);
      check("last_pulse_zero", bus.det_zero, 0);
      tick(1);
      check("check_cycle_unlocked", bus.unlocked, 0);
      check("check_cycle_active", bus.attempt_active, 1);
      tick(1);
      check("unlock_at_k2", bus.unlocked, 1);
      check("unlock_fail_count", bus.fail_count, 0);
      bus.lock_req = 1'b1;
      tick(1);
      bus.lock_req = 1'b0;
      check("relock_unlocked", bus.unlocked, 0);
      check("relock_det_reset", bus.det_reset, 1);
      tick(2);

      // Three wrong attempts into lockout, with presses during lockout.
      for (int a = 1; a <= 3; a++) begin
         enter(code_bad);
         tick(1);
         check("fail_count_step", bus.fail_count, a);
         if (a < 3) tick(1);
      end
      n = 0;
      while (bus.locked_out && n < 3000) begin
         bus.btn_zero = (n % 5 == 1) && n < 990;
         bus.btn_one  = (n % 7 == 3) && n < 990;
         n++;
         tick(1);
      end
      check("lockout_len", n, LOCKOUT_CYCLES);
      check("post_lockout_fail", bus.fail_count, 0);
      check("post_lockout_det_reset", bus.det_reset, 1);
      tick(1);
      check("post_lockout_det_reset_low", bus.det_reset, 0);
      tick(2);

      // Simultaneous rise and held key leave the digit count alone.
      bus.btn_zero = 1'b1;
      bus.btn_one  = 1'b1;
      tick(1);
      check("both_no_zero", bus.det_zero, 0);
      check("both_no_one", bus.det_one, 0);
      check("both_stays_idle", bus.attempt_active, 0);
      bus.btn_zero = 1'b0;
      bus.btn_one  = 1'b0;
      tick(2);
      press(0, 1);
      press(1, 5);
      press(1, 1);
      bus.btn_zero = 1'b1;
      bus.btn_one  = 1'b1;
      tick(1);
      bus.btn_zero = 1'b0;
      bus.btn_one  = 1'b0;
      tick(2);
      press(0, 1);
      press(0, 1);
      press(1, 1);
      check("interleaved_unlock", bus.unlocked, 1);
      bus.lock_req = 1'b1;
      tick(1);
      bus.lock_req = 1'b0;
      tick(2);

      // Entry timeout after one failure.
      enter(code_bad);
      tick(3);
      press(0, 1);
      press(1, 1);
      tick(498);
      check("timeout_still_active", bus.attempt_active, 1);
      tick(1);
      check("timeout_det_reset", bus.det_reset, 1);
      check("timeout_inactive", bus.attempt_active, 0);
      check("timeout_fail_kept", bus.fail_count, 1);
      tick(2);

      // Asynchronous reset mid-entry, then a clean unlock.
      press(0, 1);
      press(1, 1);
      press(1, 1);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_det_reset", bus.det_reset, 1);
      check("midreset_active", bus.attempt_active, 0);
      check("midreset_fail", bus.fail_count, 0);
      check("midreset_zero", bus.det_zero, 0);
      tick(1);
      reset_n = 1'b1;
      tick(1);
      enter(code_ok);
      check("post_reset_unlock", bus.unlocked, 1);
      tick(OPEN_CYCLES + 50);
      check("open_after_wait", bus.unlocked, AUTO ? 0 : 1);
      bus.lock_req = 1'b1;
      tick(1);
      bus.lock_req = 1'b0;
      tick(2);

      // Random traffic with periodic correct codes.
      for (int c = 0; c < 20000; c++) begin
         if (c % 2000 == 1000) begin
            bus.btn_zero = 1'b0;
            bus.btn_one  = 1'b0;
            bus.lock_req = 1'b0;
            tick(1);
            enter(code_ok);
            tick(20);
         end
         bus.btn_zero = ($urandom % 3) == 0;
         bus.btn_one  = ($urandom % 3) == 0;
         bus.lock_req = ($urandom % 16) == 0;
         tick(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
